// File: rtl/udma_i2c_cmd_arbiter.sv
// Round-robin arbiter that shares one I2C command/byte stream between N_REQ requesters and holds the lock until STOP/EOT.
// Latency: 1 cycle to grant from IDLE, then bytes pass straight through with no added latency.
// Backpressure: cmd_ready_i goes only to the owner's req_ready_o bit. Optional owner-stall abort under macro I2C_ARB_TIMEOUT_EN.
module udma_i2c_cmd_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDW           = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_en_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         cmd_data_o,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output logic               busy_o,
    output logic [IDW-1:0]     owner_o,
    output logic               done_o,
    output logic               abort_o
);

    // Reject configurations the arbiter cannot serve
    if (N_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("udma_i2c_cmd_arbiter: N_REQ and TIMEOUT_CYCLES must both be >= 2");
    end

`ifdef I2C_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_OPC, ST_PAY, ST_REL, ST_ABRT
    } state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_OPC, ST_PAY, ST_REL
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;

    logic [7:0]     own_data;
    logic           own_vld;
    logic           xfer;
    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;

    assign own_data = req_data_i[{owner_q, 3'b000} +: 8];
    assign own_vld  = req_valid_i[owner_q];
    assign xfer     = cmd_valid_o & cmd_ready_i;

    // Round-robin search: first eligible requester at or after rr_q, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        scan_idx  = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_en_i[scan_idx] && req_valid_i[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
            scan_idx = (scan_idx == IDW'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // Stream mux: owner passes through while locked; ABRT injects a STOP
    always_comb begin
        cmd_data_o  = 8'h00;
        cmd_valid_o = 1'b0;
        req_ready_o = '0;
        case (state_q)
            ST_OPC, ST_PAY: begin
                cmd_data_o           = own_data;
                cmd_valid_o          = own_vld;
                req_ready_o[owner_q] = cmd_ready_i;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ST_ABRT: begin
                cmd_data_o  = 8'h20;
                cmd_valid_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Next-state: grant, opcode/payload tracking, release and optional stall abort
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_idx;
                    state_d = ST_OPC;
                    busy_d  = 1'b1;
                end
            end
            ST_OPC: begin
                if (xfer) begin
                    case (own_data[7:4])
                        4'h8, 4'hA, 4'hC: begin
                            cnt_d   = 2'd1;
                            state_d = ST_PAY;
                        end
                        4'hE: begin
                            cnt_d   = 2'd2;
                            state_d = ST_PAY;
                        end
                        4'h2, 4'h9: begin
                            state_d = ST_REL;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_PAY: begin
                // Payload bytes are never decoded, so a 0x20 data byte is not a STOP
                if (xfer) begin
                    if (cnt_q == 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_OPC;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            ST_REL: begin
                rr_d    = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = ST_IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ST_ABRT: begin
                if (xfer) begin
                    state_d = ST_REL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        // Count owner-idle cycles; a stalled owner gets a STOP injected on its behalf
        if (state_q == ST_OPC || state_q == ST_PAY) begin
            if (xfer) begin
                timer_d = '0;
            end else if (!own_vld) begin
                if (timer_q == TMAX) begin
                    timer_d = '0;
                    cnt_d   = 2'd0;
                    state_d = ST_ABRT;
                    abort_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        end else begin
            timer_d = '0;
        end
`endif
    end

    // State and registered-output flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
`ifdef I2C_ARB_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign owner_o = owner_q;
    assign done_o  = done_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// Directed bench for udma_i2c_cmd_arbiter with a byte scoreboard checked by an independent monitor.
// Two requester sources feed byte queues. The expected {owner, byte} order is hand-written per test.
// The monitor pops one entry per downstream transfer and also tracks done/abort pulses and ready masking.
module tb_udma_i2c_cmd_arbiter;
    localparam int N  = 2;
    localparam int TO = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   req_en_i;
    logic [15:0]  req_data_i;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [7:0]   cmd_data_o;
    logic         cmd_valid_o;
    logic         cmd_ready_i;
    logic         busy_o;
    logic [0:0]   owner_o;
    logic         done_o;
    logic         abort_o;

    udma_i2c_cmd_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_en_i(req_en_i), .req_data_i(req_data_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .cmd_data_o(cmd_data_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .busy_o(busy_o),
        .owner_o(owner_o), .done_o(done_o), .abort_o(abort_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [8:0] exp_q[$];
    logic [1:0] fire;
    logic       bp = 1'b0;
    int vec = 0, miss = 0;
    int done_cnt = 0, abort_cnt = 0, cyc = 0, last_xfer_cyc = 0, abort_gap = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vec++;
        if (act !== expv) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic exp_b(input logic o, input logic [7:0] d);
        exp_q.push_back({o, d});
    endtask

    task automatic load(input int src, input logic o_unused, input logic [7:0] d);
        if (src == 0) src0_q.push_back(d); else src1_q.push_back(d);
    endtask

    // Waits until only 'keep' scoreboard entries remain and the lock is free
    task automatic drain(input string nm, input int keep);
        int t = 0;
        while ((exp_q.size() > keep || busy_o) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        repeat (2) @(negedge clk_i);
        chk({nm, "_drain"}, 32'(t < 300), 32'd1);
    endtask

    // Requester sources: present queue heads, pop on a handshake seen at the negedge
    initial begin
        req_valid_i = '0;
        req_data_i  = '0;
        cmd_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            fire = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            if (fire[0] === 1'b1) void'(src0_q.pop_front());
            if (fire[1] === 1'b1) void'(src1_q.pop_front());
            req_valid_i[0]   = (src0_q.size() > 0);
            req_valid_i[1]   = (src1_q.size() > 0);
            req_data_i[7:0]  = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
            req_data_i[15:8] = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
            cmd_ready_i      = bp ? ~cmd_ready_i : 1'b1;
        end
    end

    // Monitor: scoreboard on every transfer, pulse counters, ready masking under backpressure
    initial begin
        logic [8:0] e;
        logic [1:0] rdy_exp;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_i) begin
                if (done_o) done_cnt++;
                if (abort_o) begin
                    abort_cnt++;
                    abort_gap = cyc - last_xfer_cyc;
                end
                if (bp && busy_o && exp_q.size() > 0) begin
                    e = exp_q[0];
                    rdy_exp = cmd_ready_i ? (2'b01 << e[8]) : 2'b00;
                    chk("bp_req_ready", 32'(req_ready_o), 32'(rdy_exp));
                end
                if (cmd_valid_o && cmd_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {23'd0, owner_o, cmd_data_o}, 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_byte", {23'd0, owner_o, cmd_data_o}, {23'd0, e});
                        last_xfer_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        rst_i    = 1'b1;
        req_en_i = 2'b11;
        // Test 1/2: reset with both valid, then alternating START/STOP transactions
        for (int i = 0; i < 2; i++) begin
            load(0, 1'b0, 8'h00); load(0, 1'b0, 8'h20);
            load(1, 1'b1, 8'h00); load(1, 1'b1, 8'h20);
        end
        for (int i = 0; i < 2; i++) begin
            exp_b(1'b0, 8'h00); exp_b(1'b0, 8'h20);
            exp_b(1'b1, 8'h00); exp_b(1'b1, 8'h20);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid_in", 32'(req_valid_i), 32'h3);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_abort", 32'(abort_o), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_no_forward", 32'(cmd_valid_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        chk("grant_busy", 32'(busy_o), 32'd1);
        chk("grant_owner", 32'(owner_o), 32'd0);
        drain("fair", 0);
        chk("fair_done_cnt", 32'(done_cnt), 32'd4);

        // Test 3: WR payload 0x20 is data, not STOP; CFG carries two payload bytes
        load(0, 1'b0, 8'h00); load(0, 1'b0, 8'h80); load(0, 1'b0, 8'h20); load(0, 1'b0, 8'h20);
        load(0, 1'b0, 8'hE0); load(0, 1'b0, 8'h20); load(0, 1'b0, 8'h90); load(0, 1'b0, 8'h90);
        load(1, 1'b1, 8'h00); load(1, 1'b1, 8'h20);
        exp_b(1'b0, 8'h00); exp_b(1'b0, 8'h80); exp_b(1'b0, 8'h20); exp_b(1'b0, 8'h20);
        exp_b(1'b1, 8'h00); exp_b(1'b1, 8'h20);
        exp_b(1'b0, 8'hE0); exp_b(1'b0, 8'h20); exp_b(1'b0, 8'h90); exp_b(1'b0, 8'h90);
        drain("parse", 0);
        chk("parse_done_cnt", 32'(done_cnt), 32'd7);

        // Test 4: toggling downstream ready during a WAIT transaction from requester 1
        bp = 1'b1;
        load(1, 1'b1, 8'h00); load(1, 1'b1, 8'hA0); load(1, 1'b1, 8'h55); load(1, 1'b1, 8'h20);
        exp_b(1'b1, 8'h00); exp_b(1'b1, 8'hA0); exp_b(1'b1, 8'h55); exp_b(1'b1, 8'h20);
        drain("bp", 0);
        bp = 1'b0;
        chk("bp_done_cnt", 32'(done_cnt), 32'd8);

        // Test 5: only requester 1 enabled although rr points at 0; enable dropped mid-transaction
        req_en_i = 2'b10;
        load(0, 1'b0, 8'h00); load(0, 1'b0, 8'h20);
        load(1, 1'b1, 8'h00); load(1, 1'b1, 8'h80); load(1, 1'b1, 8'h33); load(1, 1'b1, 8'h20);
        exp_b(1'b1, 8'h00); exp_b(1'b1, 8'h80); exp_b(1'b1, 8'h33); exp_b(1'b1, 8'h20);
        exp_b(1'b0, 8'h00); exp_b(1'b0, 8'h20);
        begin
            int t = 0;
            while (src1_q.size() > 2 && t < 100) begin
                @(negedge clk_i);
                t++;
            end
            chk("en_mid_reached", 32'(t < 100), 32'd1);
        end
        req_en_i = 2'b00;
        drain("en_drop", 2);
        repeat (4) @(negedge clk_i);
        chk("en_off_idle", 32'(busy_o), 32'd0);
        chk("en_off_held", 32'(src0_q.size()), 32'd2);
        req_en_i = 2'b11;
        drain("en_restore", 0);
        chk("en_done_cnt", 32'(done_cnt), 32'd10);

`ifdef I2C_ARB_TIMEOUT_EN
        // Test 6: requester 0 stalls inside a WR; arbiter injects STOP and releases
        req_en_i = 2'b01;
        load(0, 1'b0, 8'h00); load(0, 1'b0, 8'h80);
        exp_b(1'b0, 8'h00); exp_b(1'b0, 8'h80); exp_b(1'b0, 8'h20);
        drain("abort", 0);
        chk("abort_cnt", 32'(abort_cnt), 32'd1);
        // Pulse appears on the 9th negedge after the last owner byte: 8 idle cycles then registered
        chk("abort_gap", 32'(abort_gap), 32'd9);
        req_en_i = 2'b11;
        load(1, 1'b1, 8'h00); load(1, 1'b1, 8'h20);
        exp_b(1'b1, 8'h00); exp_b(1'b1, 8'h20);
        drain("after_abort", 0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd12);
`else
        chk("no_abort", 32'(abort_cnt), 32'd0);
`endif
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
